// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ID/EX ALU control stage.
package alu_ctrl_pkg;

    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_RI = 7'h13;
    localparam logic [6:0] OP_ST = 7'h23;
    localparam logic [6:0] OP_RR = 7'h33;
    localparam logic [6:0] OP_BR = 7'h63;

    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        ALUOP_RI   = 2'b00,
        ALUOP_BR   = 2'b01,
        ALUOP_LDST = 2'b10,
        ALUOP_DC   = 2'b11
    } alu_op_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        MD_WAIT = 2'b10
    } state_t;

    // Immediate ALU ops only carry a meaningful funct7[5] for the shifts.
    function automatic logic f7_fix(input logic [6:0] opcode,
                                    input logic [6:0] funct_7,
                                    input logic [2:0] funct_3);
        if (opcode == OP_RI && funct_3 != 3'b001 && funct_3 != 3'b101)
            return 1'b0;
        return funct_7[5];
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational opcode/funct/ALUop decode to {is_m, operation}.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int M_EXT = 1,
    parameter int OP_W  = 4 + M_EXT
) (
    input  logic [6:0]      i_opcode,
    input  logic [6:0]      i_funct_7,
    input  logic [2:0]      i_funct_3,
    input  logic [1:0]      i_alu_op,
    output logic            o_is_m,
    output logic [OP_W-1:0] o_operation
);

    logic [3:0] w_base;

    always_comb begin
        w_base = ALU_ADD;
        case (alu_op_t'(i_alu_op))
            ALUOP_RI: w_base = {f7_fix(i_opcode, i_funct_7, i_funct_3), i_funct_3};
            ALUOP_BR: w_base = ALU_SUB;
            default:  w_base = ALU_ADD;
        endcase

        o_is_m = (M_EXT != 0) && (alu_op_t'(i_alu_op) == ALUOP_RI) &&
                 (i_opcode == OP_RR) && (i_funct_7 == F7_MULDIV);

        o_operation = o_is_m ? OP_W'({2'b10, i_funct_3}) : OP_W'(w_base);
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage with RV32M dispatch and mul/div watchdog.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int M_EXT      = 1,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct_7,
    input  logic [2:0]       funct_3,
    input  logic [1:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4+M_EXT-1:0] operation,
    output logic             md_start,
    output logic [2:0]       md_op,
    input  logic             md_done,
    output logic             md_err,
    output logic             stall
);

    localparam int OP_W = 4 + M_EXT;
    localparam int TO_W = $clog2(MD_TIMEOUT + 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [OP_W-1:0] r_operation;
    logic            r_out_valid;
    logic            r_md_start;
    logic [2:0]      r_md_op;
    logic            r_md_err;
    logic            r_stall;
    logic [TO_W-1:0] r_wd;

    logic            w_is_m;
    logic [OP_W-1:0] w_dec_operation;
    logic [OP_W-1:0] w_md_operation;
    logic            w_accept;
    logic            w_expire;
    logic            w_load;
    logic [OP_W-1:0] w_load_val;
    logic            w_md_abort;

    alu_op_decode #(
        .M_EXT (M_EXT),
        .OP_W  (OP_W)
    ) u_decode (
        .i_opcode    (opcode),
        .i_funct_7   (funct_7),
        .i_funct_3   (funct_3),
        .i_alu_op    (ALUop),
        .o_is_m      (w_is_m),
        .o_operation (w_dec_operation)
    );

    generate
        if (M_EXT != 0) begin : g_md_op
            assign w_md_operation = OP_W'({2'b10, r_md_op});
        end else begin : g_no_md_op
            assign w_md_operation = '0;
        end
    endgenerate

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign operation = r_operation;
    assign md_start  = r_md_start;
    assign md_op     = r_md_op;
    assign md_err    = r_md_err;
    assign stall     = r_stall;

    always_comb begin
        w_next_state = r_state;
        w_accept     = in_valid && in_ready;
        w_expire     = (r_wd == TO_W'(MD_TIMEOUT - 1));
        w_load       = 1'b0;
        w_load_val   = w_dec_operation;
        w_md_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_m) w_next_state = ISSUE;
                    else        w_load       = 1'b1;
                end
            end
            ISSUE: w_next_state = MD_WAIT;
            MD_WAIT: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (md_done) begin
                    w_load       = 1'b1;
                    w_load_val   = w_md_operation;
                    w_next_state = IDLE;
                end else if (w_expire) begin
                    w_md_abort   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_operation <= '0;
            r_out_valid <= 1'b0;
            r_md_start  <= 1'b0;
            r_md_op     <= '0;
            r_md_err    <= 1'b0;
            r_stall     <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_state    <= w_next_state;
            r_md_start <= (r_state == IDLE) && (w_next_state == ISSUE);
            r_md_err   <= w_md_abort;
            r_stall    <= (w_next_state != IDLE);

            if (w_load) begin
                r_operation <= w_load_val;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if ((r_state == IDLE) && w_accept && w_is_m)
                r_md_op <= funct_3;

            if (r_state == ISSUE)
                r_wd <= '0;
            else if (r_state == MD_WAIT)
                r_wd <= r_wd + 1'b1;
        end
    end

endmodule
